// File: rtl/io_pad_conditioner_bottom_pkg.sv
// Shared constants and helpers for the pad-edge conditioners.
// The default parameters and the debounce counter width function live here.
package io_pad_pkg;

  localparam int N_IN_DEF        = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = 4;

  // Width of a counter that must hold values 0..n.
  function automatic int db_cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/io_pad_conditioner_bottom_if.sv
// Link between the pad conditioner and the bottom I/O tile of the fabric.
// Both signals are levels with no valid/ready: the tile samples GPIN and drives GPOUT on every clk edge.
interface io_pad_conditioner_bottom_if
  import io_pad_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
);

  logic [N_IN-1:0] gfpga_pad_GPIN_PAD;
  logic            gfpga_pad_GPOUT_PAD;

  // The tile reads conditioned inputs and drives its single output pad.
  modport master (
    input  gfpga_pad_GPIN_PAD,
    output gfpga_pad_GPOUT_PAD
  );

  // The conditioner drives conditioned inputs and reads the tile output.
  modport slave (
    output gfpga_pad_GPIN_PAD,
    input  gfpga_pad_GPOUT_PAD
  );

endinterface

// File: rtl/io_pad_debounce.sv
// One input channel: synchroniser chain, debouncer holding the accepted value,
// and registered rise/fall pulses that are suppressed while configuration is incomplete.
module io_pad_debounce
  import io_pad_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_done,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W    = db_cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   sync_v;
  logic                   differ;
  logic                   accept;

  assign sync_v = sync_q[SYNC_STAGES-1];

  always_comb begin
    differ = 1'b0;
    accept = 1'b0;
    differ = (sync_v != stable);
    // Acceptance happens on the DB_CYCLES-th consecutive differing sample.
    accept = differ && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      rise   <= accept &  sync_v & cfg_done;
      fall   <= accept & ~sync_v & cfg_done;
      if (!differ) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync_v;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_pad_conditioner_bottom.sv
// Bottom-edge pin conditioner: per-pin debounce channels feeding the I/O tile,
// configuration gating of the pads, and the registered chip output pin.
module io_pad_conditioner_bottom
  import io_pad_pkg::*;
#(
  parameter int N_IN        = N_IN_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_done,
  input  logic [N_IN-1:0]             pin_in,
  io_pad_conditioner_bottom_if.slave  tile,
  output logic                        pin_out,
  output logic [N_IN-1:0]             in_rise,
  output logic [N_IN-1:0]             in_fall
);

  logic [N_IN-1:0] stable;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    io_pad_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_db (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_done (cfg_done),
      .pin      (pin_in[i]),
      .stable   (stable[i]),
      .rise     (in_rise[i]),
      .fall     (in_fall[i])
    );
  end

  // Combinational gate so the fabric sees 0 in the very cycle cfg_done is low.
  assign tile.gfpga_pad_GPIN_PAD = stable & {N_IN{cfg_done}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_out <= 1'b0;
    end else begin
      pin_out <= cfg_done & tile.gfpga_pad_GPOUT_PAD;
    end
  end

endmodule

// File: tb/tb_io_pad_conditioner_bottom.sv
// Bench for io_pad_conditioner_bottom: directed scenarios plus random traffic
// against a sliding-window reference model, checked through an expected queue.
module tb_io_pad_conditioner_bottom;
  import io_pad_pkg::*;

  localparam int N  = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int W  = 3 * N + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_done = 1'b0;
  logic [N-1:0] pin_in = '0;
  logic         pin_out;
  logic [N-1:0] in_rise;
  logic [N-1:0] in_fall;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] hist_q[$];
  logic [N-1:0] m_s;
  logic [N-1:0] m_acc;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_fall;
  logic         m_pout;
  logic [W-1:0] m_e;
  logic [W-1:0] mon_e;
  logic [W-1:0] mon_a;

  io_pad_conditioner_bottom_if #(.N_IN(N)) tile_if ();

  io_pad_conditioner_bottom #(
    .N_IN        (N),
    .SYNC_STAGES (SS),
    .DB_CYCLES   (DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_done (cfg_done),
    .pin_in   (pin_in),
    .tile     (tile_if.slave),
    .pin_out  (pin_out),
    .in_rise  (in_rise),
    .in_fall  (in_fall)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference model: a pin value is accepted once the synchronised input has
  // disagreed with the accepted value for DB consecutive samples.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_s = '0;
      hist_q = {};
      for (int k = 0; k < SS + DB + 2; k++) hist_q.push_back('0);
      m_e = '0;
    end else begin
      m_acc = '0;
      for (int i = 0; i < N; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) begin
          logic [N-1:0] smp;
          smp = hist_q[hist_q.size() - SS - j];
          if (smp[i] == m_s[i]) all_diff = 1'b0;
        end
        m_acc[i] = all_diff;
      end
      m_s    = m_s ^ m_acc;
      m_rise = m_acc &  m_s & {N{cfg_done}};
      m_fall = m_acc & ~m_s & {N{cfg_done}};
      m_pout = cfg_done & tile_if.gfpga_pad_GPOUT_PAD;
      hist_q.push_back(pin_in);
      if (hist_q.size() > SS + DB + 4) void'(hist_q.pop_front());
      m_e = {m_s & {N{cfg_done}}, m_rise, m_fall, m_pout};
    end
    exp_q.push_back(m_e);
  end

  // monitor / scoreboard
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: no expected entry at time %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        mon_a = {tile_if.gfpga_pad_GPIN_PAD, in_rise, in_fall, pin_out};
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL sb_cycle @%0t: got pads=%h rise=%h fall=%h pin_out=%b, want pads=%h rise=%h fall=%h pin_out=%b",
                   $time, mon_a[W-1 -: N], mon_a[2*N -: N], mon_a[N:1], mon_a[0],
                   mon_e[W-1 -: N], mon_e[2*N -: N], mon_e[N:1], mon_e[0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic after_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver
  initial begin
    tile_if.gfpga_pad_GPOUT_PAD = 1'b0;
    rst_n    = 1'b0;
    cfg_done = 1'b0;
    pin_in   = 4'hF;
    cycles(3);
    chk("rst_pads", 32'(tile_if.gfpga_pad_GPIN_PAD), 32'h0);
    chk("rst_pulses", 32'({in_rise, in_fall}), 32'h0);
    chk("rst_pin_out", 32'(pin_out), 32'h0);

    rst_n = 1'b1;
    cycles(10);
    chk("gated_pads", 32'(tile_if.gfpga_pad_GPIN_PAD), 32'h0);
    cfg_done = 1'b1;
    #1;
    chk("cfg_rise_pads", 32'(tile_if.gfpga_pad_GPIN_PAD), 32'hF);

    // clean edge on channel 2
    cycles(1);
    pin_in = 4'h0;
    cycles(10);
    pin_in[2] = 1'b1;
    after_edges(5);
    chk("edge5_pad2", 32'(tile_if.gfpga_pad_GPIN_PAD[2]), 32'h0);
    after_edges(1);
    chk("edge6_pad2", 32'(tile_if.gfpga_pad_GPIN_PAD[2]), 32'h1);
    chk("edge6_rise", 32'(in_rise), 32'h4);
    after_edges(1);
    chk("edge7_rise", 32'(in_rise), 32'h0);
    @(negedge clk);
    pin_in[2] = 1'b0;
    after_edges(6);
    chk("fall_pad2", 32'(tile_if.gfpga_pad_GPIN_PAD[2]), 32'h0);
    chk("fall_pulse", 32'(in_fall), 32'h4);
    after_edges(1);
    chk("fall_done", 32'(in_fall), 32'h0);

    // glitch rejection on channel 0
    cycles(2);
    for (int r = 0; r < 10; r++) begin
      pin_in[0] = 1'b1;
      cycles(3);
      pin_in[0] = 1'b0;
      cycles(1);
    end
    cycles(6);
    chk("glitch_pad0", 32'(tile_if.gfpga_pad_GPIN_PAD[0]), 32'h0);

    // simultaneous channels
    pin_in = 4'hA;
    after_edges(5);
    chk("simul_edge5", 32'(tile_if.gfpga_pad_GPIN_PAD), 32'h0);
    after_edges(1);
    chk("simul_pads", 32'(tile_if.gfpga_pad_GPIN_PAD), 32'hA);
    chk("simul_rise", 32'(in_rise), 32'hA);
    after_edges(1);
    chk("simul_rise_end", 32'(in_rise), 32'h0);

    // output path
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      tile_if.gfpga_pad_GPOUT_PAD = ~tile_if.gfpga_pad_GPOUT_PAD;
    end
    @(negedge clk);
    tile_if.gfpga_pad_GPOUT_PAD = 1'b1;
    cfg_done = 1'b0;
    #1;
    chk("cfg_drop_pads", 32'(tile_if.gfpga_pad_GPIN_PAD), 32'h0);
    after_edges(1);
    chk("cfg_drop_pin_out", 32'(pin_out), 32'h0);
    cycles(3);
    cfg_done = 1'b1;

    // reset mid-debounce
    pin_in = 4'h0;
    cycles(10);
    pin_in = 4'h5;
    after_edges(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pads", 32'(tile_if.gfpga_pad_GPIN_PAD), 32'h0);
    cycles(2);
    rst_n = 1'b1;
    after_edges(5);
    chk("rerun_edge5", 32'(tile_if.gfpga_pad_GPIN_PAD), 32'h0);
    after_edges(1);
    chk("rerun_edge6", 32'(tile_if.gfpga_pad_GPIN_PAD), 32'h5);
    chk("rerun_rise", 32'(in_rise), 32'h5);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) pin_in[i] = ~pin_in[i];
      tile_if.gfpga_pad_GPOUT_PAD = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) cfg_done = ~cfg_done;
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(4);
    mon_en = 1'b0;
    cycles(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
